validation_arbiter: RTL
=======================

VALIDATION_ARBITER -- requirements
Module: validation_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of hash requesters (2..8).
REQ-002 SHALL have parameter NONCE_W, default 32, nonce width in bits.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse; begins a search.
REQ-006 SHALL have port abort  input  1  one-cycle pulse; ends a search without a result.
REQ-007 SHALL have port clear  input  1  one-cycle pulse; releases FOUND.
REQ-008 SHALL have port difficulty  input  32  compact target, sampled on accepted start.
REQ-009 SHALL have port req_valid  input  NUM_REQ  per-requester hash offered.
REQ-010 SHALL have port req_ready  output  NUM_REQ  per-requester grant, one-hot or zero.
REQ-011 SHALL have port req_hash  input  NUM_REQ*256  packed hashes, requester i at [256*i+255:256*i].
REQ-012 SHALL have port req_nonce  input  NUM_REQ*NONCE_W  packed nonces.
REQ-013 SHALL have port busy  output  1  state is not IDLE.
REQ-014 SHALL have port found  output  1  state is FOUND.
REQ-015 SHALL have port found_nonce  output  NONCE_W  winning nonce, valid while found.
REQ-016 SHALL have port found_id  output  $clog2(NUM_REQ)  winning requester index.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, FOUND.
REQ-018 IDLE: req_ready=0; start with abort low -> RUN, latch difficulty; start and abort together -> stay IDLE.
REQ-019 RUN: each cycle grant at most one requester with req_valid=1, round-robin, search starting at last granted index + 1 (wraps NUM_REQ-1 -> 0); pointer reset value NUM_REQ-1.
REQ-020 req_ready SHALL be combinational from req_valid and the pointer; transfer = req_valid[i] & req_ready[i].
REQ-021 Transferred hash SHALL drive the validator in the transfer cycle; nonce, index and a valid bit SHALL be registered alongside, so result, nonce and index align one cycle later (latency 1).
REQ-022 Aligned valid & success in RUN -> FOUND next edge; found_nonce/found_id captured from the aligned registers.
REQ-023 Transfer in the same cycle as a detected success SHALL be consumed and its result discarded.
REQ-024 FOUND: req_ready=0; found_nonce/found_id held; clear -> IDLE; start ignored.
REQ-025 abort in RUN or FOUND -> IDLE; in-flight result discarded; abort wins over success and clear in the same cycle.
REQ-026 difficulty changes outside an accepted start SHALL have no effect.
REQ-027 Comparison SHALL be hash (byte-reversed) strictly less than mantissa << 8*(exp-3), per the existing validator.

Reset
REQ-028 rst SHALL force IDLE, req_ready=0, busy=0, found=0, found_nonce=0, found_id=0, pipeline valid=0, pointer=NUM_REQ-1, latched difficulty=0.
REQ-029 rst mid-search SHALL drop any in-flight result.

Configuration
REQ-030 With VALIDATION_ARBITER_STATS_EN defined: output hash_count (32) counts results evaluated in RUN, saturates at 0xFFFFFFFF, clears on accepted start and rst; without it the port and counter SHALL NOT exist.

Structure
REQ-031 A shared package SHALL hold the state enum, HASH_W=256 and DIFF_W=32.
REQ-032 SHALL instantiate standard_hash_validator as the single shared validator; round-robin selection SHALL be a sub-module rr_arbiter.

Verification
REQ-033 difficulty=0x0000FF20, req0 hash all-zero, nonce 0x11 -> found=1 two cycles after transfer, found_nonce=0x11, found_id=0.
REQ-034 All four requesters valid, hashes all-FF -> grants 0,1,2,3,0 on successive cycles, found stays 0.
REQ-035 Success on req2 while req3 transfers in the same cycle -> found_id=2, req3 result discarded.
REQ-036 abort in the cycle the aligned result succeeds -> IDLE, found=0.
REQ-037 start and abort together in IDLE -> busy stays 0.
REQ-038 rst asserted during RUN with a transfer in flight -> all outputs zero that cycle, no FOUND after release.

Source files
------------

// File: rtl/validation_arbiter_pkg.sv
// Shared types and constants for the validation arbiter slice.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package validation_arbiter_pkg;

   localparam int HASH_W = 256;
   localparam int DIFF_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FOUND = 2'd2
   } state_t;

   // Hashes arrive little-endian; the first byte on the bus is the least
   // significant byte of the numeric value compared against the target.
   function automatic logic [HASH_W-1:0] byte_rev(input logic [HASH_W-1:0] h);
      logic [HASH_W-1:0] r;
      r = '0;
      for (int b = 0; b < HASH_W/8; b++) begin
         r[b*8 +: 8] = h[(HASH_W/8-1-b)*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/standard_hash_validator.sv
// Compares a hash against a compact difficulty target: value(hash) < mantissa << 8*(exp-3).
// Latency: 1 cycle, result registered on the rising edge after the hash is presented.
// Backpressure: none; accepts a new hash every cycle.
module standard_hash_validator
   import validation_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [HASH_W-1:0] hash,
   input  logic [DIFF_W-1:0] difficulty,
   output logic              ok
);

   // Target is built in a field wide enough for the largest exponent that
   // still fits the mantissa; anything larger overflows 2^256 and always passes.
   localparam int EXT_W = HASH_W + 32;

   logic [7:0]       exp_b;
   logic [23:0]      mant;
   int               exp_i;
   logic [EXT_W-1:0] mant_ext;
   logic [EXT_W-1:0] target;
   logic [EXT_W-1:0] hash_ext;
   logic             huge;
   logic             pass;

   // Difficulty word is stored little-endian: exponent in the low byte,
   // mantissa bytes following in ascending significance order reversed.
   assign exp_b    = difficulty[7:0];
   assign mant     = {difficulty[15:8], difficulty[23:16], difficulty[31:24]};
   assign exp_i    = int'(exp_b);
   assign mant_ext = {{(EXT_W-24){1'b0}}, mant};
   assign hash_ext = {32'b0, byte_rev(hash)};

   // Expand the compact target and compare strictly-less.
   always_comb begin
      target = '0;
      huge   = 1'b0;
      if (exp_i < 3) begin
         target = mant_ext >> (8 * (3 - exp_i));
      end else if (exp_i <= 36) begin
         target = mant_ext << (8 * (exp_i - 3));
      end else begin
         huge = (mant != 24'd0);
      end
      pass = huge || (hash_ext < target);
   end

   // Register the verdict so it lines up with the sideband pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ok <= 1'b0;
      end else begin
         ok <= pass;
      end
   end

endmodule

// File: rtl/validation_arbiter_rr_arbiter.sv
// Round-robin grant among N requesters, search begins one past the last grant.
// Latency: grant is combinational from req and the stored pointer; pointer updates on grant.
// Backpressure: grants nothing while en is low; at most one grant per cycle.
module rr_arbiter #(
   parameter  int N     = 4,
   localparam int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N - 1);

   logic [IDX_W-1:0] last;
   logic             hit;
   int               idx;
   logic [IDX_W-1:0] idx_l;

   // Scan from last+1 with wrap; first active request wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      hit       = 1'b0;
      idx       = 0;
      idx_l     = '0;
      for (int k = 1; k <= N; k++) begin
         idx   = (int'(last) + k) % N;
         idx_l = idx[IDX_W-1:0];
         if (en && !hit && req[idx_l]) begin
            hit          = 1'b1;
            grant[idx_l] = 1'b1;
            grant_idx    = idx_l;
         end
      end
   end

   // Remember the most recent winner; reset points at the top index so
   // requester 0 is searched first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= LAST_RST;
      end else if (hit) begin
         last <= grant_idx;
      end
   end

endmodule

// File: rtl/validation_arbiter.sv
// Arbitrates hash requesters into one shared validator and latches the first passing nonce.
// Latency: grant combinational; verdict 1 cycle after transfer; found asserts on the following edge.
// Backpressure: req_ready per requester, one-hot or zero, only while searching. Optional: VALIDATION_ARBITER_STATS_EN adds hash_count.
module validation_arbiter
   import validation_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int NONCE_W = 32,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic                       clear,
   input  logic [DIFF_W-1:0]          difficulty,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*HASH_W-1:0]  req_hash,
   input  logic [NUM_REQ*NONCE_W-1:0] req_nonce,
   output logic                       busy,
   output logic                       found,
   output logic [NONCE_W-1:0]         found_nonce,
`ifdef VALIDATION_ARBITER_STATS_EN
   output logic [31:0]                hash_count,
`endif
   output logic [ID_W-1:0]            found_id
);

   state_t              state;
   state_t              state_nxt;
   logic [DIFF_W-1:0]   diff_q;
   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     grant_idx;
   logic [HASH_W-1:0]   sel_hash;
   logic [NONCE_W-1:0]  sel_nonce;
   logic                pipe_vld;
   logic [NONCE_W-1:0]  pipe_nonce;
   logic [ID_W-1:0]     pipe_id;
   logic                val_ok;
   logic                start_ok;
   logic                run_en;

   assign run_en    = (state == RUN);
   assign start_ok  = (state == IDLE) && start && !abort;
   assign req_ready = grant;
   assign busy      = (state != IDLE);
   assign found     = (state == FOUND);

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .clk       (clk),
      .rst       (rst),
      .en        (run_en),
      .req       (req_valid),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Route the granted requester's hash and nonce; zero when nothing transfers.
   always_comb begin
      sel_hash  = '0;
      sel_nonce = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_hash  = req_hash[i*HASH_W +: HASH_W];
            sel_nonce = req_nonce[i*NONCE_W +: NONCE_W];
         end
      end
   end

   standard_hash_validator u_val (
      .clk        (clk),
      .rst        (rst),
      .hash       (sel_hash),
      .difficulty (diff_q),
      .ok         (val_ok)
   );

   // Next-state: abort beats a success or a clear arriving in the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_ok) state_nxt = RUN;
         end
         RUN: begin
            if (abort)                  state_nxt = IDLE;
            else if (pipe_vld && val_ok) state_nxt = FOUND;
         end
         FOUND: begin
            if (abort || clear) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Difficulty is only sampled when a search is actually accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         diff_q <= '0;
      end else if (start_ok) begin
         diff_q <= difficulty;
      end
   end

   // Sideband pipeline alongside the validator; a transfer made while the
   // search is ending (success or abort) is consumed but never marked valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld   <= 1'b0;
         pipe_nonce <= '0;
         pipe_id    <= '0;
      end else begin
         pipe_vld <= (|grant) && (state_nxt == RUN);
         if (|grant) begin
            pipe_nonce <= sel_nonce;
            pipe_id    <= grant_idx;
         end
      end
   end

   // Capture the winner on the RUN to FOUND transition and hold it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         found_nonce <= '0;
         found_id    <= '0;
      end else if (run_en && (state_nxt == FOUND)) begin
         found_nonce <= pipe_nonce;
         found_id    <= pipe_id;
      end
   end

`ifdef VALIDATION_ARBITER_STATS_EN
   // Count verdicts seen while searching; sticks at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hash_count <= '0;
      end else if (start_ok) begin
         hash_count <= '0;
      end else if (run_en && pipe_vld && (hash_count != 32'hFFFF_FFFF)) begin
         hash_count <= hash_count + 32'd1;
      end
   end
`endif

endmodule
